// File: rtl/add_arbiter.sv
// add_arbiter: two requesters share one N-bit ripple-carry adder through a
// round-robin arbiter feeding a one-entry result buffer (EMPTY/FULL).
// Optional feature: define ADD_ARB_COUT_EN to add the res_cout port, which
// carries the adder's carry out of bit N-1 alongside res_sum.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. reqX_ready is combinational and high only for the requester
// granted this cycle. res_valid is a registered FULL flag; the buffer may
// drain (res_ready) and refill (new grant) on the same edge.
module add_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         req1_ready,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_sum,
  output logic         res_id
`ifdef ADD_ARB_COUT_EN
  ,
  output logic         res_cout
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // state is the buffer FSM; visible hierarchically for checkers
  state_t       state;
  logic         ptr;        // preferred requester on contention
  logic         slot_free;
  logic         grant0;
  logic         grant1;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [N-1:0] sum;
  logic [N-1:1] carry;      // carry[i] is the carry into bit i
`ifdef ADD_ARB_COUT_EN
  logic         cout;
`endif

  // Slot is free when empty, or full and being drained this cycle.
  // Held low during reset so no ready pulses escape.
  assign slot_free = !rst && ((state == EMPTY) || res_ready);

  // Round-robin grant: the pointer only matters when both are valid
  assign grant0 = slot_free && req0_valid && (!req1_valid || !ptr);
  assign grant1 = slot_free && req1_valid && (!req0_valid || ptr);

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign res_valid  = (state == FULL);

  // Operand mux in front of the single shared adder
  assign op_a = grant1 ? req1_a : req0_a;
  assign op_b = grant1 ? req1_b : req0_b;

  // Ripple-carry adder: half adder at bit 0, full adders above, no carry-in
  assign sum[0]   = op_a[0] ^ op_b[0];
  assign carry[1] = op_a[0] & op_b[0];

  for (genvar i = 1; i < N; i++) begin : g_fa
    assign sum[i] = op_a[i] ^ op_b[i] ^ carry[i];
    if (i < N - 1) begin : g_carry
      assign carry[i+1] = (op_a[i] & op_b[i]) | (carry[i] & (op_a[i] ^ op_b[i]));
    end
  end

`ifdef ADD_ARB_COUT_EN
  // Carry out of the top bit, only built when it is exported
  assign cout = (op_a[N-1] & op_b[N-1]) | (carry[N-1] & (op_a[N-1] ^ op_b[N-1]));
`endif

  // Buffer FSM, result registers and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      res_sum <= '0;
      res_id  <= 1'b0;
      ptr     <= 1'b0;
`ifdef ADD_ARB_COUT_EN
      res_cout <= 1'b0;
`endif
    end else if (grant0 || grant1) begin
      state   <= FULL;
      res_sum <= sum;
      res_id  <= grant1;
      ptr     <= grant0;  // point at the requester that was not granted
`ifdef ADD_ARB_COUT_EN
      res_cout <= cout;
`endif
    end else if ((state == FULL) && res_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: randomized and directed stimulus for add_arbiter with a
// queue-based scoreboard. Define ADD_ARB_COUT_EN to build against the
// res_cout variant.
module tb_add_arbiter;

  localparam int N = 32;
  localparam int W = N + 2;  // {cout, id, sum}

  logic         clk;
  logic         rst;
  logic         v[2];
  logic [N-1:0] a_in[2];
  logic [N-1:0] b_in[2];
  logic         rr;
  logic         req0_ready;
  logic         req1_ready;
  logic         res_valid;
  logic [N-1:0] res_sum;
  logic         res_id;
`ifdef ADD_ARB_COUT_EN
  logic         res_cout;
`endif

  add_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (v[0]),
    .req0_a     (a_in[0]),
    .req0_b     (b_in[0]),
    .req0_ready (req0_ready),
    .req1_valid (v[1]),
    .req1_a     (a_in[1]),
    .req1_b     (b_in[1]),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_ready  (rr),
    .res_sum    (res_sum),
    .res_id     (res_id)
`ifdef ADD_ARB_COUT_EN
    ,
    .res_cout   (res_cout)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;
  logic took[2];
  int   m_pref = 0;  // model: preferred requester
  bit   m_full = 0;  // model: a result is waiting

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] dut_result();
    logic c;
`ifdef ADD_ARB_COUT_EN
    c = res_cout;
`else
    c = 1'b0;
`endif
    return {c, res_id, res_sum};
  endfunction

  // Reference model: decides who should be granted from the arbitration
  // rules and predicts the result the grant produces.
  always @(negedge clk) begin
    logic [N:0] s;
    logic [W-1:0] e;
    int g;
    took[0] = v[0] && req0_ready;
    took[1] = v[1] && req1_ready;
    if (chk_en) begin
      check("res_valid", {{(W-1){1'b0}}, res_valid}, {{(W-1){1'b0}}, m_full});
      g = -1;
      if (!m_full || rr) begin
        if (v[0] && v[1]) g = m_pref;
        else if (v[0])    g = 0;
        else if (v[1])    g = 1;
      end
      check("req0_ready", {{(W-1){1'b0}}, req0_ready}, {{(W-1){1'b0}}, (g == 0)});
      check("req1_ready", {{(W-1){1'b0}}, req1_ready}, {{(W-1){1'b0}}, (g == 1)});
      if (g >= 0) begin
        s = {1'b0, a_in[g]} + {1'b0, b_in[g]};
`ifdef ADD_ARB_COUT_EN
        e = {s[N], (g == 1), s[N-1:0]};
`else
        e = {1'b0, (g == 1), s[N-1:0]};
`endif
        exp_q.push_back(e);
        m_pref = 1 - g;
        m_full = 1;
      end else if (m_full && rr) begin
        m_full = 0;
      end
    end
  end

  // Monitor: compares the presented result with the oldest expectation
  // every cycle it is shown, and retires it on the consumer handshake.
  always @(negedge clk) begin
    if (chk_en && res_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", dut_result(), {W{1'bx}});
      end else begin
        check("result", dut_result(), exp_q[0]);
        if (rr) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Each requester keeps its pair until accepted, then picks a new one.
  task automatic drive(input int cycles, input int p_valid, input int p_ready);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (!v[i] || took[i]) begin
          v[i]    = ($urandom_range(99) < p_valid);
          a_in[i] = $urandom;
          b_in[i] = $urandom;
        end
      end
      rr = ($urandom_range(99) < p_ready);
    end
  endtask

  // Present one pair on a single requester and wait (bounded) for acceptance
  task automatic send(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
    int n;
    @(posedge clk);
    #1;
    v[id] = 1'b1;
    a_in[id] = a;
    b_in[id] = b;
    rr = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!took[id] && n < 20);
    if (!took[id]) check("send_timeout", 0, 1);
    v[id] = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pref = 0;
    m_full = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    rr  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b1;  // valid during reset must not be accepted
      a_in[i] = 32'h1234_5678;
      b_in[i] = 32'h1111_1111;
      took[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", {{(W-1){1'b0}}, res_valid}, '0);
    check("rst_result", dut_result(), '0);
    check("rst_req0_ready", {{(W-1){1'b0}}, req0_ready}, '0);
    check("rst_req1_ready", {{(W-1){1'b0}}, req1_ready}, '0);
    v[0] = 1'b0;
    v[1] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // idle with consumer ready: nothing happens
    repeat (3) @(posedge clk);

    // single requester pairs, including wrap-around
    send(0, 32'h0000_0005, 32'h0000_0003);
    send(1, 32'hFFFF_FFFF, 32'h0000_0001);
    send(1, 32'h8000_0000, 32'h8000_0000);

    // both busy, consumer always ready: alternating one-per-cycle
    drive(10, 100, 100);

    // stall with both waiting, then release
    drive(3, 100, 0);
    drive(3, 100, 100);

    // asynchronous reset while a result is held
    drive(2, 100, 0);
    @(negedge clk);
    #2;
    check("pre_rst_full", {{(W-1){1'b0}}, res_valid}, {{(W-1){1'b0}}, 1'b1});
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {{(W-1){1'b0}}, res_valid}, '0);
    check("async_rst_result", dut_result(), '0);
    check("async_rst_ready", {{(W-2){1'b0}}, req1_ready, req0_ready}, '0);
    model_reset();
    @(posedge clk);
    #1;
    v[0] = 1'b1;
    v[1] = 1'b1;
    rr = 1'b1;
    rst = 1'b0;
    chk_en = 1'b1;
    drive(4, 100, 100);

    // random traffic and backpressure
    drive(400, 70, 70);

    // drain: everything predicted must have been delivered
    drive(6, 0, 100);
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
